row_fetch_ctrl: RTL and testbench

ROW_FETCH_CTRL -- requirements
Module: row_fetch_ctrl

---
 rtl/cad_pkg.sv | 18 +
 rtl/row_fetch_ctrl_if.sv | 35 +++
 rtl/row_fetch_ctrl.sv | 108 ++++++++++
 tb/tb_row_fetch_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cad_pkg.sv
`default_nettype none
// cad_pkg: shared state encoding and word geometry for the row fetch controller.
// Rev 1.0
package cad_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_LOAD = 3'd2,
    ST_HOLD = 3'd3,
    ST_DONE = 3'd4
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/row_fetch_ctrl_if.sv
`default_nettype none
// row_fetch_ctrl_if: job, memory-read and byte-buffer signals of the row fetch controller.
// Rev 1.0
interface row_fetch_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 8
);

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  num_words;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              buf_ld;
  logic [1:0]        buf_col;
  logic [7:0]        buf_data;
  logic              word_valid;
  logic              word_ack;
  logic              busy;
  logic              done;

  // master is the controller side; slave is the job issuer / memory / buffer side
  modport master (
    input  start, base_addr, num_words, mem_data, word_ack,
    output mem_rd, mem_addr, buf_ld, buf_col, buf_data, word_valid, busy, done
  );

  modport slave (
    output start, base_addr, num_words, mem_data, word_ack,
    input  mem_rd, mem_addr, buf_ld, buf_col, buf_data, word_valid, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/row_fetch_ctrl.sv
`default_nettype none
// row_fetch_ctrl: fetches num_words 4-byte words byte by byte from a synchronous memory into a 1x4 buffer.
// Rev 1.0
module row_fetch_ctrl
  import cad_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  row_fetch_ctrl_if.master bus
);

  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BYTES_PER_WORD - 1);

  fetch_state_t            state, state_nxt;
  logic [ADDR_W-1:0]       cur_addr, cur_addr_nxt;
  logic [CNT_W-1:0]        words_left, words_left_nxt;
  logic [BYTE_IDX_W-1:0]   byte_cnt, byte_cnt_nxt;

  logic                    mem_rd;
  logic [ADDR_W-1:0]       mem_addr;
  logic                    buf_ld;
  logic [1:0]              buf_col;
  logic                    word_valid;
  logic                    done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cur_addr   <= '0;
      words_left <= '0;
      byte_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      cur_addr   <= cur_addr_nxt;
      words_left <= words_left_nxt;
      byte_cnt   <= byte_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cur_addr_nxt   = cur_addr;
    words_left_nxt = words_left;
    byte_cnt_nxt   = byte_cnt;
    mem_rd         = 1'b0;
    mem_addr       = '0;
    buf_ld         = 1'b0;
    buf_col        = '0;
    word_valid     = 1'b0;
    done           = 1'b0;

    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          cur_addr_nxt   = bus.base_addr;
          words_left_nxt = bus.num_words;
          byte_cnt_nxt   = '0;
          state_nxt      = (bus.num_words == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        mem_rd    = 1'b1;
        mem_addr  = cur_addr;
        state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        // the byte requested in READ is on mem_data this cycle
        buf_ld       = 1'b1;
        buf_col      = byte_cnt;
        cur_addr_nxt = cur_addr + ADDR_W'(1);
        byte_cnt_nxt = byte_cnt + BYTE_IDX_W'(1);
        if (byte_cnt == LAST_BYTE) begin
          words_left_nxt = words_left - CNT_W'(1);
          state_nxt      = ST_HOLD;
        end else begin
          state_nxt = ST_READ;
        end
      end
      ST_HOLD: begin
        word_valid = 1'b1;
        if (bus.word_ack) begin
          state_nxt = (words_left != '0) ? ST_READ : ST_DONE;
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.mem_rd     = mem_rd;
  assign bus.mem_addr   = mem_addr;
  assign bus.buf_ld     = buf_ld;
  assign bus.buf_col    = buf_col;
  assign bus.buf_data   = bus.mem_data;
  assign bus.word_valid = word_valid;
  assign bus.done       = done;
  assign bus.busy       = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_row_fetch_ctrl.sv
`default_nettype none
// tb_row_fetch_ctrl: table-driven and randomized checks of row_fetch_ctrl against a job-level model.
// Rev 1.0
module tb_row_fetch_ctrl;

  localparam int BPW = 4;

  typedef struct {
    logic [15:0] base;
    int          n;
    int          d;
    bit          noise;
    int          exp_lds;
    int          exp_done;
  } vec_t;

  logic clk;
  logic rst;
  logic [7:0] mem [65536];
  logic [7:0] mem_q;
  int checks;
  int errors;
  vec_t vecs[6];

  row_fetch_ctrl_if #(.ADDR_W(16), .CNT_W(8)) bus ();

  row_fetch_ctrl #(.ADDR_W(16), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous memory: data one cycle after the read strobe
  always @(posedge clk) begin
    if (bus.mem_rd) mem_q <= mem[bus.mem_addr];
  end
  assign bus.mem_data = mem_q;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_rd"},     int'(bus.mem_rd),     0);
    chk({tag, "_mem_addr"},   int'(bus.mem_addr),   0);
    chk({tag, "_buf_ld"},     int'(bus.buf_ld),     0);
    chk({tag, "_buf_col"},    int'(bus.buf_col),    0);
    chk({tag, "_word_valid"}, int'(bus.word_valid), 0);
    chk({tag, "_busy"},       int'(bus.busy),       0);
    chk({tag, "_done"},       int'(bus.done),       0);
  endtask

  // One job: model = ordered list of byte addresses base+i (mod 2^16), column i%4.
  task automatic run_job(input logic [15:0] base, input int n, input int d, input bit noise,
                         input int exp_lds, input int exp_done);
    logic [15:0] q_rd[$];
    logic [15:0] q_ld[$];
    logic [15:0] a;
    int cyc = 0, n_rd = 0, n_ld = 0, n_valid = 0, hold = 0;
    int done_cyc = -1, first_rd = -1, first_ld = -1;
    for (int i = 0; i < n * BPW; i++) q_rd.push_back(base + 16'(i));
    q_ld = q_rd;

    @(negedge clk);
    bus.base_addr = base;
    bus.num_words = 8'(n);
    bus.start     = 1'b1;
    while (done_cyc < 0 && cyc < exp_done + 40) begin
      @(negedge clk);
      cyc++;
      bus.start = 1'b0;
      chk("busy", int'(bus.busy), 1);
      chk("exclusive", $countones({bus.mem_rd, bus.buf_ld, bus.word_valid, bus.done}) <= 1 ? 1 : 0, 1);
      if (bus.mem_rd) begin
        n_rd++;
        if (first_rd < 0) first_rd = cyc;
        a = (q_rd.size() > 0) ? q_rd.pop_front() : 16'h0;
        chk("rd_addr", int'(bus.mem_addr), int'(a));
      end else begin
        chk("addr_idle_zero", int'(bus.mem_addr), 0);
      end
      if (bus.buf_ld) begin
        if (first_ld < 0) first_ld = cyc;
        a = (q_ld.size() > 0) ? q_ld.pop_front() : 16'h0;
        chk("ld_col", int'(bus.buf_col), n_ld % BPW);
        chk("ld_data", int'(bus.buf_data), int'(mem[a]));
        n_ld++;
      end else begin
        chk("col_idle_zero", int'(bus.buf_col), 0);
      end
      if (bus.word_valid) begin
        n_valid++;
        hold++;
      end else begin
        hold = 0;
      end
      if (bus.done) done_cyc = cyc;
      if (bus.word_valid)
        bus.word_ack = (hold == d + 1);
      else
        bus.word_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise && !bus.done) begin
        bus.start     = 1'($urandom_range(0, 1));
        bus.base_addr = 16'($urandom);
        bus.num_words = 8'($urandom);
      end
    end
    bus.start    = 1'b0;
    bus.word_ack = 1'b0;
    chk("n_buf_ld", n_ld, exp_lds);
    chk("n_mem_rd", n_rd, exp_lds);
    chk("done_cycle", done_cyc, exp_done);
    chk("valid_cycles", n_valid, n * (d + 1));
    chk("rd_left", q_rd.size(), 0);
    if (n > 0) begin
      chk("first_rd_cycle", first_rd, 1);
      chk("first_ld_cycle", first_ld, 2);
    end
    @(negedge clk);
    chk("idle_after_busy", int'(bus.busy), 0);
    chk("idle_after_done", int'(bus.done), 0);
  endtask

  initial begin
    int n_ld;
    int cyc;
    int rn;
    int rd;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.start     = 1'b0;
    bus.word_ack  = 1'b0;
    bus.base_addr = '0;
    bus.num_words = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0010] = 8'hAA;
    mem[16'h0011] = 8'hBB;
    mem[16'h0012] = 8'hCC;
    mem[16'h0013] = 8'hDD;

    vecs[0] = '{16'h0010, 1, 0, 1'b0, 4, 10};
    vecs[1] = '{16'h0100, 3, 5, 1'b0, 12, 43};
    vecs[2] = '{16'h0200, 0, 0, 1'b0, 0, 1};
    vecs[3] = '{16'hFFFE, 1, 2, 1'b0, 4, 12};
    vecs[4] = '{16'h3000, 2, 1, 1'b1, 8, 21};
    vecs[5] = '{16'hFFFC, 2, 0, 1'b1, 8, 19};

    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", int'(bus.busy), 0);

    for (int v = 0; v < 6; v++)
      run_job(vecs[v].base, vecs[v].n, vecs[v].d, vecs[v].noise, vecs[v].exp_lds, vecs[v].exp_done);

    // reset in the middle of a job, right after the second byte load
    @(negedge clk);
    bus.base_addr = 16'h1230;
    bus.num_words = 8'd2;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n_ld = 0;
    cyc  = 0;
    while (n_ld < 2 && cyc < 40) begin
      if (bus.buf_ld) n_ld++;
      if (n_ld < 2) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("rst_wait_two_loads", n_ld, 2);
    #2 rst = 1'b1;
    #1 check_reset_outputs("mid_job_reset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_reset_done", int'(bus.done), 0);
      chk("post_reset_busy", int'(bus.busy), 0);
    end
    run_job(16'h0400, 1, 0, 1'b0, 4, 10);

    // randomized jobs; expectations from the throughput rules
    for (int j = 0; j < 20; j++) begin
      rn = $urandom_range(0, 4);
      rd = $urandom_range(0, 3);
      run_job(16'($urandom), rn, rd, 1'($urandom_range(0, 1)), rn * BPW, rn * (2 * BPW + 1 + rd) + 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
